seq_alu: RTL

Parametrised multicycle ALU for the next-generation basic processor. It accepts one operation at a time over a valid/ready handshake. It executes logic and arithmetic ops in one cycle and variable-amount shifts at one bit position per cycle, then returns result, carry and zero flags through an output valid/ready handshake. It sits between the decode stage and register writeback and replaces the fixed-width combinational ALU.

---
 rtl/seq_alu.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu
//  Purpose  : Multicycle ALU with valid/ready handshakes on both sides.
//             Logic and arithmetic ops finish in one cycle.
//             Shifts advance one bit position per cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_alu #(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         carry,
  output logic         zero
);

  // Shift-amount width is derived from W and is not meant to be overridden.
  localparam int SHW = $clog2(W);

  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_LSH = 3'b001;
  localparam logic [2:0] c_OP_RSH = 3'b010;
  localparam logic [2:0] c_OP_XOR = 3'b011;
  localparam logic [2:0] c_OP_AND = 3'b100;
  localparam logic [2:0] c_OP_OR  = 3'b101;
  localparam logic [2:0] c_OP_SUB = 3'b110;
  localparam logic [2:0] c_OP_ASR = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [W-1:0]     r_acc;
  logic [SHW-1:0]   r_cnt;
  logic             r_carry;
  logic             r_zero;
  logic [2:0]       r_op;

  logic             w_accept;
  logic             w_is_shift;
  logic [SHW-1:0]   w_amt;
  logic [W:0]       w_sum;
  logic [W:0]       w_diff;
  logic [W-1:0]     w_alu_res;
  logic             w_alu_c;
  logic [W-1:0]     w_shf_res;
  logic             w_shf_c;

  assign in_ready   = (r_state == S_IDLE) && !Reset;
  assign w_accept   = in_valid && in_ready;
  assign w_is_shift = (op == c_OP_LSH) || (op == c_OP_RSH) || (op == c_OP_ASR);
  assign w_amt      = b[SHW-1:0];

  // Both arithmetic ops are formed at W+1 bits; the top bit is the carry
  // (for SUB a set carry means no borrow).
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};

  assign out_valid = (r_state == S_DONE);
  assign result    = r_acc;
  assign carry     = r_carry;
  assign zero      = r_zero;

  // Single-cycle result; shifts just load the operand with a cleared carry.
  always_comb begin
    w_alu_res = a;
    w_alu_c   = 1'b0;
    case (op)
      c_OP_ADD: begin w_alu_res = w_sum[W-1:0];  w_alu_c = w_sum[W];  end
      c_OP_SUB: begin w_alu_res = w_diff[W-1:0]; w_alu_c = w_diff[W]; end
      c_OP_XOR: w_alu_res = a ^ b;
      c_OP_AND: w_alu_res = a & b;
      c_OP_OR:  w_alu_res = a | b;
      default:  w_alu_res = a;
    endcase
  end

  // One-position shift step of the accumulator for the captured opcode.
  always_comb begin
    w_shf_res = r_acc;
    w_shf_c   = 1'b0;
    case (r_op)
      c_OP_LSH: begin w_shf_res = {r_acc[W-2:0], 1'b0};       w_shf_c = r_acc[W-1]; end
      c_OP_RSH: begin w_shf_res = {1'b0, r_acc[W-1:1]};       w_shf_c = r_acc[0];   end
      c_OP_ASR: begin w_shf_res = {r_acc[W-1], r_acc[W-1:1]}; w_shf_c = r_acc[0];   end
      default:  begin w_shf_res = r_acc;                      w_shf_c = 1'b0;       end
    endcase
  end

  // Next-state logic: zero-amount shifts skip SHIFT entirely.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (w_is_shift && (w_amt != '0)) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        if (r_cnt == SHW'(1)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; reset aborts any in-flight operation.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Datapath: capture at acceptance, step during SHIFT, hold in DONE.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
      r_op    <= 3'b000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= op;
            r_acc   <= w_alu_res;
            r_carry <= w_alu_c;
            r_zero  <= (w_alu_res == '0);
            r_cnt   <= w_is_shift ? w_amt : '0;
          end
        end
        S_SHIFT: begin
          r_acc   <= w_shf_res;
          r_carry <= w_shf_c;
          r_zero  <= (w_shf_res == '0);
          r_cnt   <= r_cnt - SHW'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
